io_port_responder: RTL

//  Memory-side responder for the CPU bus: decodes one 256-byte I/O page and responds to the
//  CPU's active-low mem_oe/mem_we strobes. Holds a TX FIFO (CPU writes -> serial/peripheral side),
//  an RX FIFO (peripheral side -> CPU reads), sticky status and an IRQ. Sits beside RAM/ROM on the D bus.

---
 rtl/io_port_responder_if.sv | 36 +++
 rtl/io_port_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : io_port_responder_if
//  Description : CPU-side strobe bus plus peripheral TX/RX handshakes for the
//                I/O page responder. The slave modport is the responder view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface io_port_responder_if;
  // CPU bus
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        mem_oe_n;
  logic        mem_we_n;
  // Peripheral side
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  // Interrupt
  logic        irq;

  modport slave (
    input  addr, data_in, mem_oe_n, mem_we_n, tx_ready, rx_data, rx_valid,
    output data_out, data_oe, tx_data, tx_valid, rx_ready, irq
  );

  modport master (
    output addr, data_in, mem_oe_n, mem_we_n, tx_ready, rx_data, rx_valid,
    input  data_out, data_oe, tx_data, tx_valid, rx_ready, irq
  );
endinterface
`default_nettype wire

// File: rtl/io_port_responder.sv
`default_nettype none
// ============================================================================
//  Module      : io_port_responder
//  Description : Memory-side responder for one 256-byte I/O page. CPU stores
//                to DATA feed a TX FIFO, CPU loads from DATA drain an RX FIFO,
//                with sticky overflow status, interrupt enables and a
//                registered IRQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_port_responder #(
  parameter logic [7:0]  BASE       = 8'hFF,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic               clk,
  input  logic               rst,
  io_port_responder_if.slave bus
);

  localparam int unsigned         c_depth      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_full_cnt   = (DEPTH_LOG2 + 1)'(c_depth);
  localparam logic [2:0]          c_reg_data   = 3'd0;
  localparam logic [2:0]          c_reg_status = 3'd1;
  localparam logic [2:0]          c_reg_ie     = 3'd2;

  // --------------------------------------------------------------------------
  // Strobe capture stage
  // --------------------------------------------------------------------------
  logic                  we_q;
  logic                  oe_q;
  logic                  addr_hit_q;   // registered page hit of the strobed address
  logic [2:0]            addr_reg_q;   // registered register offset of the strobed address
  logic [7:0]            data_q;

  // A read only counts when the write strobe is idle; both strobes low is a
  // write, so it must never arm the end-of-read pop.
  logic                  w_rd_strobe_n;
  logic                  w_live_hit;
  logic                  w_unused_addr_bits;

  assign w_rd_strobe_n      = bus.mem_oe_n | ~bus.mem_we_n;
  assign w_live_hit         = (bus.addr[15:8] == BASE);
  // Offsets alias across the page; the middle address bits carry no meaning.
  assign w_unused_addr_bits = ^{1'b0, bus.addr[7:3]};

  // Sample the strobes every cycle and hold the address/data of the active access
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q       <= 1'b1;
      oe_q       <= 1'b1;
      addr_hit_q <= 1'b0;
      addr_reg_q <= 3'd0;
      data_q     <= 8'h00;
    end else begin
      we_q <= bus.mem_we_n;
      oe_q <= w_rd_strobe_n;
      if (!bus.mem_we_n || !w_rd_strobe_n) begin
        addr_hit_q <= w_live_hit;
        addr_reg_q <= bus.addr[2:0];
      end
      if (!bus.mem_we_n) begin
        data_q <= bus.data_in;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Access decode: one commit at the trailing edge of each strobe
  // --------------------------------------------------------------------------
  logic w_wr_commit;
  logic w_wr_sel;
  logic w_wr_data;
  logic w_wr_status;
  logic w_wr_ie;
  logic w_rd_end;

  assign w_wr_commit = ~we_q & bus.mem_we_n;
  assign w_wr_sel    = w_wr_commit & addr_hit_q;
  assign w_wr_data   = w_wr_sel & (addr_reg_q == c_reg_data);
  assign w_wr_status = w_wr_sel & (addr_reg_q == c_reg_status);
  assign w_wr_ie     = w_wr_sel & (addr_reg_q == c_reg_ie);
  assign w_rd_end    = ~oe_q & bus.mem_oe_n;

  // --------------------------------------------------------------------------
  // FIFO state
  // --------------------------------------------------------------------------
  logic [7:0]            tx_mem_q [0:c_depth-1];
  logic [DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [DEPTH_LOG2-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [DEPTH_LOG2:0]   tx_cnt_q,    tx_cnt_d;

  logic [7:0]            rx_mem_q [0:c_depth-1];
  logic [DEPTH_LOG2-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [DEPTH_LOG2:0]   rx_cnt_q,    rx_cnt_d;

  logic                  tx_ovf_q, tx_ovf_d;
  logic                  rx_ovf_q, rx_ovf_d;
  logic [1:0]            ie_q,     ie_d;
  logic                  irq_q,    irq_d;

  logic w_tx_empty;
  logic w_tx_full;
  logic w_tx_valid;
  logic w_tx_pop;
  logic w_tx_push;
  logic w_tx_drop;

  logic w_rx_empty;
  logic w_rx_full;
  logic w_rx_ready;
  logic w_rx_push;
  logic w_rx_pop;

  assign w_tx_empty = (tx_cnt_q == '0);
  assign w_tx_full  = (tx_cnt_q == c_full_cnt);
  assign w_tx_valid = rst & ~w_tx_empty;
  assign w_tx_pop   = w_tx_valid & bus.tx_ready;
  // A full FIFO still takes the byte when the peripheral frees a slot this cycle
  assign w_tx_push  = rst & w_wr_data & (~w_tx_full | w_tx_pop);
  assign w_tx_drop  = w_wr_data & w_tx_full & ~w_tx_pop;

  assign w_rx_empty = (rx_cnt_q == '0);
  assign w_rx_full  = (rx_cnt_q == c_full_cnt);
  assign w_rx_ready = rst & ~w_rx_full;
  assign w_rx_push  = bus.rx_valid & w_rx_ready;
  assign w_rx_pop   = rst & w_rd_end & addr_hit_q & (addr_reg_q == c_reg_data) & ~w_rx_empty;

  // TX FIFO pointer and occupancy update
  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    if (w_tx_push) begin
      tx_wr_ptr_d = tx_wr_ptr_q + 1'b1;
    end
    if (w_tx_pop) begin
      tx_rd_ptr_d = tx_rd_ptr_q + 1'b1;
    end
    case ({w_tx_push, w_tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
      2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  // RX FIFO pointer and occupancy update
  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    if (w_rx_push) begin
      rx_wr_ptr_d = rx_wr_ptr_q + 1'b1;
    end
    if (w_rx_pop) begin
      rx_rd_ptr_d = rx_rd_ptr_q + 1'b1;
    end
    case ({w_rx_push, w_rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
      2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  // Sticky flags (set beats W1C), interrupt enables and the IRQ request
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;
    ie_d     = ie_q;
    if (w_wr_status && data_q[5]) begin
      tx_ovf_d = 1'b0;
    end
    if (w_wr_status && data_q[4]) begin
      rx_ovf_d = 1'b0;
    end
    if (w_tx_drop) begin
      tx_ovf_d = 1'b1;
    end
    if (bus.rx_valid && w_rx_full) begin
      rx_ovf_d = 1'b1;
    end
    if (w_wr_ie) begin
      ie_d = data_q[1:0];
    end
    irq_d = (ie_q[0] & ~w_rx_empty) | (ie_q[1] & w_tx_empty);
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      tx_ovf_q    <= 1'b0;
      rx_ovf_q    <= 1'b0;
      ie_q        <= 2'b00;
      irq_q       <= 1'b0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_ovf_q    <= rx_ovf_d;
      ie_q        <= ie_d;
      irq_q       <= irq_d;
    end
  end

  // FIFO storage; contents need no reset because occupancy guards every read
  always_ff @(posedge clk) begin
    if (w_tx_push) begin
      tx_mem_q[tx_wr_ptr_q] <= data_q;
    end
    if (w_rx_push) begin
      rx_mem_q[rx_wr_ptr_q] <= bus.rx_data;
    end
  end

  // --------------------------------------------------------------------------
  // Read path: zero-latency decode of the live address
  // --------------------------------------------------------------------------
  logic       w_data_oe;
  logic [7:0] w_rd_val;

  assign w_data_oe = rst & w_live_hit & ~bus.mem_oe_n & bus.mem_we_n;

  // Register read multiplexer
  always_comb begin
    w_rd_val = 8'h00;
    case (bus.addr[2:0])
      c_reg_data:   w_rd_val = w_rx_empty ? 8'h00 : rx_mem_q[rx_rd_ptr_q];
      c_reg_status: w_rd_val = {2'b00, tx_ovf_q, rx_ovf_q,
                                w_tx_full, w_tx_empty, w_rx_full, ~w_rx_empty};
      c_reg_ie:     w_rd_val = {6'b000000, ie_q};
      default:      w_rd_val = 8'h00;
    endcase
  end

  assign bus.data_oe  = w_data_oe;
  assign bus.data_out = w_data_oe ? w_rd_val : 8'h00;
  assign bus.tx_data  = tx_mem_q[tx_rd_ptr_q];
  assign bus.tx_valid = w_tx_valid;
  assign bus.rx_ready = w_rx_ready;
  assign bus.irq      = irq_q;

endmodule
`default_nettype wire
